// File: rtl/tank_motion.sv
// Tank heading/position update, one frame step per frame_tick.
// Define TANK_MOTION_WRAP_EN to wrap at the playfield edge instead of clamping.
module tank_motion #(
  parameter int COORD_W   = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 240,
  parameter int HEAD_INIT = 0,
  parameter int ROT_DIV   = 4,
  parameter int SPEED     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                left,
  input  logic                right,
  input  logic                thrust,
  output logic [3:0]          heading,
  output logic signed [7:0]   motion_x,
  output logic signed [7:0]   motion_y,
  output logic [COORD_W-1:0]  pos_x,
  output logic [COORD_W-1:0]  pos_y,
  output logic                at_edge,
  output logic                update_done
);

  localparam int CW2 = COORD_W + 2;

  if (COORD_W < 6 || COORD_W > 30) begin : g_bad_cw
    $error("tank_motion: COORD_W out of range");
  end
  if (ROT_DIV < 1 || ROT_DIV > 15) begin : g_bad_rot
    $error("tank_motion: ROT_DIV out of range");
  end
  if (SPEED < 1 || SPEED > 4) begin : g_bad_spd
    $error("tank_motion: SPEED out of range");
  end
  if (HEAD_INIT < 0 || HEAD_INIT > 15) begin : g_bad_head
    $error("tank_motion: HEAD_INIT out of range");
  end
  if (X_MAX < 15 || X_MAX >= (1 << COORD_W)) begin : g_bad_xmax
    $error("tank_motion: X_MAX out of range");
  end
  if (Y_MAX < 15 || Y_MAX >= (1 << COORD_W)) begin : g_bad_ymax
    $error("tank_motion: Y_MAX out of range");
  end
  if (X_INIT < 0 || X_INIT > X_MAX) begin : g_bad_xini
    $error("tank_motion: X_INIT out of range");
  end
  if (Y_INIT < 0 || Y_INIT > Y_MAX) begin : g_bad_yini
    $error("tank_motion: Y_INIT out of range");
  end

  localparam logic signed [7:0]     SPD   = 8'(SPEED);
  localparam logic [3:0]            RLAST = 4'(ROT_DIV - 1);
  localparam logic [3:0]            HINI  = 4'(HEAD_INIT);
  localparam logic signed [CW2-1:0] XM    = CW2'(X_MAX);
  localparam logic signed [CW2-1:0] YM    = CW2'(Y_MAX);

  typedef enum logic [1:0] {
    S_WAIT,
    S_ROT,
    S_MOVE
  } state_e;

  function automatic logic signed [7:0] tab_x(input logic [3:0] h);
    logic signed [7:0] v;
    case (h)
      4'd0, 4'd8:         v = 8'sd0;
      4'd1, 4'd7:         v = -8'sd1;
      4'd2, 4'd6:         v = -8'sd2;
      4'd3, 4'd4, 4'd5:   v = -8'sd3;
      4'd9, 4'd15:        v = 8'sd1;
      4'd10, 4'd14:       v = 8'sd2;
      default:            v = 8'sd3;
    endcase
    return v;
  endfunction

  function automatic logic signed [7:0] tab_y(input logic [3:0] h);
    logic signed [7:0] v;
    case (h)
      4'd0, 4'd1, 4'd15:  v = -8'sd3;
      4'd2, 4'd14:        v = -8'sd2;
      4'd3, 4'd13:        v = -8'sd1;
      4'd4, 4'd12:        v = 8'sd0;
      4'd5, 4'd11:        v = 8'sd1;
      4'd6, 4'd10:        v = 8'sd2;
      default:            v = 8'sd3;
    endcase
    return v;
  endfunction

  // Returns {adjusted, coordinate} for one axis after an unbounded move.
  function automatic logic [COORD_W:0] bound(
    input logic signed [CW2-1:0] s,
    input logic signed [CW2-1:0] mx
  );
    logic signed [CW2-1:0] r;
    logic                  adj;
    r   = s;
    adj = 1'b0;
    if (s[CW2-1]) begin
      adj = 1'b1;
`ifdef TANK_MOTION_WRAP_EN
      r = s + mx + CW2'(1);
`else
      r = '0;
`endif
    end else if (s > mx) begin
      adj = 1'b1;
`ifdef TANK_MOTION_WRAP_EN
      r = s - mx - CW2'(1);
`else
      r = mx;
`endif
    end
    return {adj, r[COORD_W-1:0]};
  endfunction

  state_e                 state_q, state_d;
  logic [3:0]             rot_q, rot_d;
  logic [3:0]             head_q, head_d;
  logic signed [7:0]      mx_q, mx_d;
  logic signed [7:0]      my_q, my_d;
  logic [COORD_W-1:0]     px_q, px_d;
  logic [COORD_W-1:0]     py_q, py_d;
  logic                   edge_q, edge_d;
  logic                   done_q, done_d;

  logic signed [CW2-1:0]  sx, sy;
  logic [COORD_W:0]       bx, by;

  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    head_d  = head_q;
    mx_d    = mx_q;
    my_d    = my_q;
    px_d    = px_q;
    py_d    = py_q;
    edge_d  = edge_q;
    done_d  = 1'b0;
    sx      = $signed({2'b00, px_q}) + CW2'(mx_q);
    sy      = $signed({2'b00, py_q}) + CW2'(my_q);
    bx      = bound(sx, XM);
    by      = bound(sy, YM);
    unique case (state_q)
      S_WAIT: begin
        if (frame_tick) state_d = S_ROT;
      end
      S_ROT: begin
        state_d = S_MOVE;
        if (left ^ right) begin
          if (rot_q == 4'd0) begin
            head_d = left ? head_q + 4'd1 : head_q - 4'd1;
          end
          rot_d = (rot_q == RLAST) ? 4'd0 : rot_q + 4'd1;
        end else begin
          rot_d = 4'd0;
        end
        mx_d = tab_x(head_d) * SPD;
        my_d = tab_y(head_d) * SPD;
      end
      S_MOVE: begin
        state_d = S_WAIT;
        done_d  = 1'b1;
        if (thrust) begin
          px_d   = bx[COORD_W-1:0];
          py_d   = by[COORD_W-1:0];
          edge_d = bx[COORD_W] | by[COORD_W];
        end else begin
          edge_d = 1'b0;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      rot_q   <= 4'd0;
      head_q  <= HINI;
      mx_q    <= tab_x(HINI) * SPD;
      my_q    <= tab_y(HINI) * SPD;
      px_q    <= COORD_W'(X_INIT);
      py_q    <= COORD_W'(Y_INIT);
      edge_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      head_q  <= head_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      px_q    <= px_d;
      py_q    <= py_d;
      edge_q  <= edge_d;
      done_q  <= done_d;
    end
  end

  assign heading     = head_q;
  assign motion_x    = mx_q;
  assign motion_y    = my_q;
  assign pos_x       = px_q;
  assign pos_y       = py_q;
  assign at_edge     = edge_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_tank_motion.sv
// Bench for tank_motion: frame-level model checked every cycle plus
// literal expectations for the directed scenarios.
module tb_tank_motion;

  localparam int SPEED   = 1;
  localparam int ROT_DIV = 4;
  localparam int XM      = 639;
  localparam int YM      = 479;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_tick = 1'b0;
  logic              left = 1'b0;
  logic              right = 1'b0;
  logic              thrust = 1'b0;
  logic [3:0]        heading;
  logic signed [7:0] motion_x;
  logic signed [7:0] motion_y;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              at_edge;
  logic              update_done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  int tx[16] = '{0, -1, -2, -3, -3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1};
  int ty[16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  // Model: expected outputs, plus cycles elapsed since an accepted tick.
  int eh, ex, ey, eedge, edone, age, turnk;

  tank_motion dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .left        (left),
    .right       (right),
    .thrust      (thrust),
    .heading     (heading),
    .motion_x    (motion_x),
    .motion_y    (motion_y),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .at_edge     (at_edge),
    .update_done (update_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      eh = 0; ex = 320; ey = 240;
      eedge = 0; edone = 0; age = 0; turnk = 0;
    end else begin
      edone = 0;
      if (age == 1) begin
        if (left != right) begin
          if (turnk % ROT_DIV == 0) eh = (eh + (left ? 1 : 15)) % 16;
          turnk++;
        end else begin
          turnk = 0;
        end
        age = 2;
      end else if (age == 2) begin
        if (thrust) begin
          int nx, ny;
          nx = ex + tx[eh] * SPEED;
          ny = ey + ty[eh] * SPEED;
          eedge = (nx < 0 || nx > XM || ny < 0 || ny > YM) ? 1 : 0;
`ifdef TANK_MOTION_WRAP_EN
          if (nx < 0) nx += XM + 1; else if (nx > XM) nx -= XM + 1;
          if (ny < 0) ny += YM + 1; else if (ny > YM) ny -= YM + 1;
`else
          if (nx < 0) nx = 0; else if (nx > XM) nx = XM;
          if (ny < 0) ny = 0; else if (ny > YM) ny = YM;
`endif
          ex = nx; ey = ny;
        end else begin
          eedge = 0;
        end
        edone = 1;
        age = 0;
      end else if (frame_tick) begin
        age = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({heading, motion_x, motion_y, pos_x, pos_y, at_edge, update_done} !==
          {4'(eh), 8'(tx[eh] * SPEED), 8'(ty[eh] * SPEED), 10'(ex), 10'(ey),
           1'(eedge), 1'(edone)}) begin
        failures++;
        $display("FAIL model t=%0t actual h=%0d m=(%0d,%0d) p=(%0d,%0d) e=%0b d=%0b required h=%0d m=(%0d,%0d) p=(%0d,%0d) e=%0d d=%0d",
                 $time, heading, motion_x, motion_y, pos_x, pos_y, at_edge, update_done,
                 eh, tx[eh] * SPEED, ty[eh] * SPEED, ex, ey, eedge, edone);
      end
    end
  end

  always @(negedge clk) begin
    if (update_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pos_x", int'(pos_x), 320);
    chk("rst_pos_y", int'(pos_y), 240);
    chk("rst_heading", int'(heading), 0);
    chk("rst_motion_x", int'(motion_x), 0);
    chk("rst_motion_y", int'(motion_y), -3);
    chk("rst_at_edge", int'(at_edge), 0);
    chk("rst_done", int'(update_done), 0);

    thrust = 1'b1;
    d0 = done_cnt;
    frame();
    thrust = 1'b0;
    chk("thrust_pos_y", int'(pos_y), 237);
    chk("thrust_pos_x", int'(pos_x), 320);
    chk("thrust_done_cnt", done_cnt - d0, 1);

    left = 1'b1;
    frame();
    chk("left_tick1", int'(heading), 1);
    repeat (3) frame();
    chk("left_tick4", int'(heading), 1);
    frame();
    chk("left_tick5", int'(heading), 2);
    left = 1'b0;

    thrust = 1'b1;
    frame();
    thrust = 1'b0;
    chk("diag_pos_x", int'(pos_x), 318);
    chk("diag_pos_y", int'(pos_y), 235);

    right = 1'b1;
    repeat (5) frame();
    right = 1'b0;
    chk("back_to_up", int'(heading), 0);

    thrust = 1'b1;
    repeat (78) frame();
    chk("near_edge_y", int'(pos_y), 1);
    chk("near_edge_flag", int'(at_edge), 0);
    frame();
`ifdef TANK_MOTION_WRAP_EN
    chk("edge_y", int'(pos_y), 478);
`else
    chk("edge_y", int'(pos_y), 0);
`endif
    chk("edge_x", int'(pos_x), 318);
    chk("edge_flag", int'(at_edge), 1);
    thrust = 1'b0;
    frame();
    chk("edge_clear", int'(at_edge), 0);

    thrust = 1'b1;
    d0 = done_cnt;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) begin frame_tick = 1'b0; reset = 1'b1; end
    @(negedge clk) reset = 1'b0;
    thrust = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_pos_x", int'(pos_x), 320);
    chk("midreset_pos_y", int'(pos_y), 240);
    chk("midreset_done", done_cnt - d0, 0);

    right = 1'b1;
    frame();
    right = 1'b0;
    chk("right_heading", int'(heading), 15);
    chk("right_motion_x", int'(motion_x), 1);
    chk("right_motion_y", int'(motion_y), -3);

    left = 1'b1;
    right = 1'b1;
    d0 = done_cnt;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    left = 1'b0;
    right = 1'b0;
    chk("both_heading", int'(heading), 15);
    chk("both_done_cnt", done_cnt - d0, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
